// File: rtl/vx_dvg_stack_pkg.sv
// Shared types and default sizing for the divergence stack.
package vx_dvg_stack_pkg;

   localparam int unsigned DV_NUM_WARPS   = 4;
   localparam int unsigned DV_NUM_THREADS = 4;
   localparam int unsigned DV_PC_BITS     = 32;
   localparam int unsigned DV_STACK_SIZE  = 4;
   localparam int unsigned DV_STACK_SIZEW = $clog2(DV_STACK_SIZE + 1);

   // One reconvergence record; field order matches the packed RAM word.
   typedef struct packed {
      logic [DV_NUM_THREADS-1:0] orig_tmask;
      logic [DV_NUM_THREADS-1:0] else_tmask;
      logic [DV_PC_BITS-1:0]     else_pc;
   } dvg_entry_t;

endpackage

// File: rtl/vx_dvg_stack_ram.sv
// One-write / one-sync-read entry RAM; a read of the address being written returns the new data.
module vx_dvg_stack_ram #(
   parameter int unsigned DATA_W  = 40,
   parameter int unsigned ENTRIES = 16,
   localparam int unsigned AW     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [ENTRIES];
   logic [DATA_W-1:0] rdata_q, rdata_d;

   // Read-during-write bypass so a same-cycle write is never missed.
   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = (we && (waddr == raddr)) ? wdata : mem_q[raddr];
   end

   // Storage and registered read port; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/vx_dvg_stack.sv
// Per-warp IPDOM divergence stack: split pushes, join flips phase or pops, 1-cycle join response.
module vx_dvg_stack
   import vx_dvg_stack_pkg::*;
#(
   parameter int unsigned NUM_WARPS   = DV_NUM_WARPS,
   parameter int unsigned NUM_THREADS = DV_NUM_THREADS,
   parameter int unsigned DEPTH       = DV_STACK_SIZE,
   parameter int unsigned PC_BITS     = DV_PC_BITS,
   localparam int unsigned PTRW       = $clog2(DEPTH + 1),
   localparam int unsigned NW_WIDTH   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   split_valid,
   input  logic [NW_WIDTH-1:0]    split_wid,
   input  logic                   split_is_dvg,
   input  logic [NUM_THREADS-1:0] split_tmask,
   input  logic [NUM_THREADS-1:0] split_else_tmask,
   input  logic [PC_BITS-1:0]     split_next_pc,
   input  logic                   join_valid,
   input  logic [NW_WIDTH-1:0]    join_wid,
   input  logic [PTRW-1:0]        join_stack_ptr,
   input  logic [NW_WIDTH-1:0]    ptr_wid,
   output logic [PTRW-1:0]        ptr_out,
   output logic                   rsp_valid,
   output logic [NW_WIDTH-1:0]    rsp_wid,
   output logic [NUM_THREADS-1:0] rsp_tmask,
   output logic [PC_BITS-1:0]     rsp_pc,
   output logic                   rsp_branch,
   output logic                   err_overflow,
   output logic                   err_underflow,
   output logic                   err_collision
);

   localparam int unsigned ENTRIES = NUM_WARPS * DEPTH;
   localparam int unsigned AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam int unsigned EW      = 2 * NUM_THREADS + PC_BITS;

   // Flat {wid, level} index shared by the RAM and the phase bits.
   function automatic logic [AW-1:0] ent_addr(input logic [NW_WIDTH-1:0] wid,
                                              input logic [PTRW-1:0] lvl);
      return AW'(wid) * AW'(DEPTH) + AW'(lvl);
   endfunction

   logic [PTRW-1:0]     ptr_q [NUM_WARPS];
   logic [PTRW-1:0]     ptr_d [NUM_WARPS];
   logic [ENTRIES-1:0]  phase_q, phase_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_branch_q, rsp_branch_d;
   logic [NW_WIDTH-1:0] rsp_wid_q, rsp_wid_d;
   logic                err_ovf_q, err_ovf_d;
   logic                err_unf_q, err_unf_d;
   logic                err_col_q, err_col_d;

   logic                ram_we, ram_re;
   logic [AW-1:0]       ram_waddr, ram_raddr;
   logic [EW-1:0]       ram_wdata, ram_rdata;
   logic [PTRW-1:0]     split_ptr, join_ptr, join_top;

   // Next-state for pointers, phase bits, response and error flags.
   always_comb begin
      ptr_d        = ptr_q;
      phase_d      = phase_q;
      rsp_valid_d  = 1'b0;
      rsp_branch_d = 1'b0;
      rsp_wid_d    = rsp_wid_q;
      err_ovf_d    = err_ovf_q;
      err_unf_d    = err_unf_q;
      err_col_d    = err_col_q;
      ram_we       = 1'b0;
      ram_re       = 1'b0;
      split_ptr    = ptr_q[split_wid];
      join_ptr     = ptr_q[join_wid];
      join_top     = join_ptr - PTRW'(1);
      ram_waddr    = ent_addr(split_wid, split_ptr);
      ram_raddr    = ent_addr(join_wid, join_top);
      ram_wdata    = {split_tmask, split_else_tmask, split_next_pc};

      if (split_valid && split_is_dvg) begin
         if (split_ptr == PTRW'(DEPTH)) begin
            err_ovf_d = 1'b1;
         end else begin
            ram_we               = 1'b1;
            phase_d[ram_waddr]   = 1'b0;
            ptr_d[split_wid]     = split_ptr + PTRW'(1);
         end
      end

      // A join coinciding with a split is dropped; the split always wins.
      if (split_valid && join_valid) begin
         err_col_d = 1'b1;
      end else if (join_valid && (join_stack_ptr != join_ptr)) begin
         if (join_ptr == '0) begin
            err_unf_d = 1'b1;
         end else begin
            ram_re      = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_wid_d   = join_wid;
            if (!phase_q[ram_raddr]) begin
               phase_d[ram_raddr] = 1'b1;
               rsp_branch_d       = 1'b1;
            end else begin
               ptr_d[join_wid] = join_top;
            end
         end
      end
   end

   // Control state register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int w = 0; w < int'(NUM_WARPS); w++) ptr_q[w] <= '0;
         phase_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_branch_q <= 1'b0;
         rsp_wid_q    <= '0;
         err_ovf_q    <= 1'b0;
         err_unf_q    <= 1'b0;
         err_col_q    <= 1'b0;
      end else begin
         ptr_q        <= ptr_d;
         phase_q      <= phase_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_branch_q <= rsp_branch_d;
         rsp_wid_q    <= rsp_wid_d;
         err_ovf_q    <= err_ovf_d;
         err_unf_q    <= err_unf_d;
         err_col_q    <= err_col_d;
      end
   end

   vx_dvg_stack_ram #(
      .DATA_W  (EW),
      .ENTRIES (ENTRIES)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   // Select the response fields from the RAM word; zero when idle since RAM is not reset.
   always_comb begin
      rsp_tmask = '0;
      rsp_pc    = '0;
      if (rsp_valid_q) begin
         rsp_tmask = rsp_branch_q ? ram_rdata[PC_BITS +: NUM_THREADS]
                                  : ram_rdata[EW-1 -: NUM_THREADS];
         if (rsp_branch_q) rsp_pc = ram_rdata[PC_BITS-1:0];
      end
   end

   assign ptr_out       = ptr_q[ptr_wid];
   assign rsp_valid     = rsp_valid_q;
   assign rsp_wid       = rsp_wid_q;
   assign rsp_branch    = rsp_branch_q;
   assign err_overflow  = err_ovf_q;
   assign err_underflow = err_unf_q;
   assign err_collision = err_col_q;

endmodule

// File: tb/tb_vx_dvg_stack.sv
// Directed vector bench for vx_dvg_stack (4 warps, 4 threads, depth 4, 32-bit PC).
module tb_vx_dvg_stack;

   logic        clk = 1'b0;
   logic        reset;
   logic        split_valid, split_is_dvg, join_valid;
   logic [1:0]  split_wid, join_wid, ptr_wid;
   logic [3:0]  split_tmask, split_else_tmask;
   logic [31:0] split_next_pc;
   logic [2:0]  join_stack_ptr, ptr_out;
   logic        rsp_valid, rsp_branch;
   logic [1:0]  rsp_wid;
   logic [3:0]  rsp_tmask;
   logic [31:0] rsp_pc;
   logic        err_overflow, err_underflow, err_collision;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   vx_dvg_stack #(
      .NUM_WARPS   (4),
      .NUM_THREADS (4),
      .DEPTH       (4),
      .PC_BITS     (32)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .split_valid      (split_valid),
      .split_wid        (split_wid),
      .split_is_dvg     (split_is_dvg),
      .split_tmask      (split_tmask),
      .split_else_tmask (split_else_tmask),
      .split_next_pc    (split_next_pc),
      .join_valid       (join_valid),
      .join_wid         (join_wid),
      .join_stack_ptr   (join_stack_ptr),
      .ptr_wid          (ptr_wid),
      .ptr_out          (ptr_out),
      .rsp_valid        (rsp_valid),
      .rsp_wid          (rsp_wid),
      .rsp_tmask        (rsp_tmask),
      .rsp_pc           (rsp_pc),
      .rsp_branch       (rsp_branch),
      .err_overflow     (err_overflow),
      .err_underflow    (err_underflow),
      .err_collision    (err_collision)
   );

   // op bit0 = split, bit1 = join; expectations are sampled 1 ns after the edge.
   typedef struct {
      logic [1:0]  op;
      logic [1:0]  swid;
      logic        dvg;
      logic [3:0]  tm;
      logic [3:0]  el;
      logic [31:0] pc;
      logic [1:0]  jwid;
      logic [2:0]  sp;
      logic [1:0]  qwid;
      logic [2:0]  eptr;
      logic        ev;
      logic [3:0]  etm;
      logic [31:0] epc;
      logic        ebr;
      logic [2:0]  eerr;  // {collision, underflow, overflow}
   } vec_t;

   vec_t vecs[$];

   function automatic void spl(logic [1:0] w, logic d, logic [3:0] tm, logic [3:0] el,
                               logic [31:0] pc, logic [2:0] eptr, logic [2:0] eerr);
      vecs.push_back('{2'b01, w, d, tm, el, pc, 2'd0, 3'd0, w, eptr, 1'b0, 4'h0, 32'h0,
                       1'b0, eerr});
   endfunction

   function automatic void jn(logic [1:0] w, logic [2:0] sp, logic [2:0] eptr, logic ev,
                              logic [3:0] etm, logic [31:0] epc, logic ebr, logic [2:0] eerr);
      vecs.push_back('{2'b10, 2'd0, 1'b0, 4'h0, 4'h0, 32'h0, w, sp, w, eptr, ev, etm, epc,
                       ebr, eerr});
   endfunction

   function automatic void idl(logic [1:0] q, logic [2:0] eptr, logic [2:0] eerr);
      vecs.push_back('{2'b00, 2'd0, 1'b0, 4'h0, 4'h0, 32'h0, 2'd0, 3'd0, q, eptr, 1'b0, 4'h0,
                       32'h0, 1'b0, eerr});
   endfunction

   task automatic chk(string name, int idx, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s vec=%0d got=%0h expected=%0h", name, idx, got, exp);
      end
   endtask

   task automatic idle_inputs();
      split_valid = 1'b0; split_wid = '0; split_is_dvg = 1'b0; split_tmask = '0;
      split_else_tmask = '0; split_next_pc = '0; join_valid = 1'b0; join_wid = '0;
      join_stack_ptr = '0; ptr_wid = '0;
   endtask

   initial begin
      vec_t v;
      idle_inputs();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int w = 0; w < 4; w++) begin
         ptr_wid = 2'(w);
         #1 chk("reset_ptr", w, 32'(ptr_out), 32'd0);
      end
      chk("reset_rsp_valid", -1, 32'(rsp_valid), 32'd0);
      chk("reset_err", -1, {29'd0, err_collision, err_underflow, err_overflow}, 32'd0);
      reset = 1'b1;

      // Push then pop twice on w1.
      spl(2'd1, 1'b1, 4'hF, 4'hC, 32'h100, 3'd1, 3'b000);
      jn (2'd1, 3'd0, 3'd1, 1'b1, 4'hC, 32'h100, 1'b1, 3'b000);
      jn (2'd1, 3'd0, 3'd0, 1'b1, 4'hF, 32'h0, 1'b0, 3'b000);
      // Non-divergent split and join.
      spl(2'd1, 1'b0, 4'hF, 4'h3, 32'h180, 3'd0, 3'b000);
      jn (2'd1, 3'd0, 3'd0, 1'b0, 4'h0, 32'h0, 1'b0, 3'b000);
      // Nest to full depth on w0, overflow, then unwind.
      spl(2'd0, 1'b1, 4'hF, 4'h1, 32'h10, 3'd1, 3'b000);
      spl(2'd0, 1'b1, 4'hE, 4'h2, 32'h20, 3'd2, 3'b000);
      spl(2'd0, 1'b1, 4'hC, 4'h4, 32'h30, 3'd3, 3'b000);
      spl(2'd0, 1'b1, 4'h9, 4'h8, 32'h40, 3'd4, 3'b000);
      spl(2'd0, 1'b1, 4'h3, 4'h3, 32'h50, 3'd4, 3'b001);
      jn (2'd0, 3'd3, 3'd4, 1'b1, 4'h8, 32'h40, 1'b1, 3'b001);
      jn (2'd0, 3'd3, 3'd3, 1'b1, 4'h9, 32'h0, 1'b0, 3'b001);
      jn (2'd0, 3'd2, 3'd3, 1'b1, 4'h4, 32'h30, 1'b1, 3'b001);
      jn (2'd0, 3'd2, 3'd2, 1'b1, 4'hC, 32'h0, 1'b0, 3'b001);
      jn (2'd0, 3'd1, 3'd2, 1'b1, 4'h2, 32'h20, 1'b1, 3'b001);
      jn (2'd0, 3'd1, 3'd1, 1'b1, 4'hE, 32'h0, 1'b0, 3'b001);
      jn (2'd0, 3'd0, 3'd1, 1'b1, 4'h1, 32'h10, 1'b1, 3'b001);
      jn (2'd0, 3'd0, 3'd0, 1'b1, 4'hF, 32'h0, 1'b0, 3'b001);
      // Underflow on w2, others untouched.
      jn (2'd2, 3'd1, 3'd0, 1'b0, 4'h0, 32'h0, 1'b0, 3'b011);
      idl(2'd0, 3'd0, 3'b011);
      idl(2'd1, 3'd0, 3'b011);
      // Split->join hazards and back-to-back joins on w3.
      spl(2'd3, 1'b1, 4'hB, 4'h4, 32'h200, 3'd1, 3'b011);
      jn (2'd3, 3'd0, 3'd1, 1'b1, 4'h4, 32'h200, 1'b1, 3'b011);
      spl(2'd3, 1'b1, 4'h3, 4'h2, 32'h300, 3'd2, 3'b011);
      jn (2'd3, 3'd1, 3'd2, 1'b1, 4'h2, 32'h300, 1'b1, 3'b011);
      jn (2'd3, 3'd1, 3'd1, 1'b1, 4'h3, 32'h0, 1'b0, 3'b011);
      jn (2'd3, 3'd0, 3'd0, 1'b1, 4'hB, 32'h0, 1'b0, 3'b011);
      // Collision: split on w2 wins, join on w1 is dropped.
      spl(2'd1, 1'b1, 4'h5, 4'h4, 32'h500, 3'd1, 3'b011);
      vecs.push_back('{2'b11, 2'd2, 1'b1, 4'h7, 4'h1, 32'h400, 2'd1, 3'd0, 2'd2, 3'd1, 1'b0,
                       4'h0, 32'h0, 1'b0, 3'b111});
      idl(2'd1, 3'd1, 3'b111);
      jn (2'd1, 3'd0, 3'd1, 1'b1, 4'h4, 32'h500, 1'b1, 3'b111);

      foreach (vecs[i]) begin
         v = vecs[i];
         split_valid = v.op[0]; split_wid = v.swid; split_is_dvg = v.dvg;
         split_tmask = v.tm; split_else_tmask = v.el; split_next_pc = v.pc;
         join_valid = v.op[1]; join_wid = v.jwid; join_stack_ptr = v.sp; ptr_wid = v.qwid;
         @(posedge clk);
         #1;
         split_valid = 1'b0; join_valid = 1'b0;
         chk("ptr_out", i, 32'(ptr_out), 32'(v.eptr));
         chk("rsp_valid", i, 32'(rsp_valid), 32'(v.ev));
         if (v.ev) begin
            chk("rsp_wid", i, 32'(rsp_wid), 32'(v.jwid));
            chk("rsp_tmask", i, 32'(rsp_tmask), 32'(v.etm));
            chk("rsp_pc", i, rsp_pc, v.epc);
            chk("rsp_branch", i, 32'(rsp_branch), 32'(v.ebr));
         end
         chk("err", i, {29'd0, err_collision, err_underflow, err_overflow}, 32'(v.eerr));
      end

      // Reset arriving while a join is presented: no response, all state cleared.
      ptr_wid = 2'd1; join_wid = 2'd1; join_stack_ptr = 3'd0; join_valid = 1'b1;
      #1 chk("pre_update_ptr", -2, 32'(ptr_out), 32'd1);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      join_valid = 1'b0;
      chk("rst_rsp_valid", -2, 32'(rsp_valid), 32'd0);
      chk("rst_err", -2, {29'd0, err_collision, err_underflow, err_overflow}, 32'd0);
      for (int w = 0; w < 4; w++) begin
         ptr_wid = 2'(w);
         #1 chk("rst_ptr", w, 32'(ptr_out), 32'd0);
      end
      reset = 1'b1;
      @(posedge clk);
      #1 chk("post_rst_rsp_valid", -3, 32'(rsp_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
